// File: rtl/bcd_scan_pkg.sv
// bcd_scan_pkg
//   Shared definitions for the four-digit BCD counter / display scanner:
//   scan FSM state encoding, blank segment pattern, decade limits and
//   small helpers for picking digits out of the packed BCD count.
package bcd_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } scan_state_t;

    localparam logic [0:6]  SEG_BLANK = 7'b1111111;
    localparam logic [3:0]  BCD_MAX   = 4'd9;
    localparam int unsigned NDIG      = 4;

    // Digit idx (0 = units) of a packed {d3,d2,d1,d0} value.
    function automatic logic [3:0] bcd_digit(input logic [15:0] value,
                                             input logic [1:0]  idx);
        return value[{idx, 2'b00} +: 4];
    endfunction

    // True when digit idx and every more significant digit are zero.
    function automatic logic upper_digits_zero(input logic [15:0] value,
                                               input logic [1:0]  idx);
        logic z;
        z = 1'b1;
        for (int unsigned k = 0; k < NDIG; k++) begin
            if (k >= 32'(idx) && value[4*k +: 4] != 4'd0)
                z = 1'b0;
        end
        return z;
    endfunction

endpackage

// File: rtl/bcd_scan_ctrl_digit_cell.sv
// bcd_digit_cell
//   One decade stage of the BCD counter. Counts 0..9 when inc is high,
//   wraps 9 -> 0 and raises carry combinationally in that same cycle so
//   the next stage can be chained as a ripple enable.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   inc    advance this digit by one
//   clr    synchronous clear (wins over inc)
//   digit  current BCD value
//   carry  inc while digit is 9 (next stage increments)
module bcd_digit_cell
    import bcd_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);

    assign carry = inc && (digit == BCD_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= carry ? 4'd0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl
//   Four-digit decade counter plus a display sequencer that time-shares a
//   single external BCD-to-7-segment decoder across HEX0..HEX3. Each scan
//   slot drives one digit's BCD code on bcd_out, then captures the decoder's
//   active-low result (seg_in, index 0:6 = a..g) into that digit's register.
//
// Parameters:
//   TICK_DIV  clock cycles per count tick (>= 2)
//   SCAN_DIV  clock cycles per scan slot  (>= 3)
//
// Ports:
//   CLOCK_50   system clock, rising edge
//   KEY0       synchronous active-low reset
//   en         count enable
//   clr        synchronous counter clear, active-high
//   bcd_out    registered BCD code to the shared decoder
//   seg_in     decoder result for bcd_out
//   HEX0..HEX3 held segment patterns, active-low, HEX0 = units
//   digit_sel  digit currently being driven/captured
//   count      packed BCD count {d3,d2,d1,d0}
//   carry_out  one-cycle pulse after a 9999 -> 0000 wrap
//
// Build option:
//   BCD_SCAN_LEADING_ZERO_BLANK_EN  blank leading zeros on HEX3..HEX1
module bcd_scan_ctrl
    import bcd_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        CLOCK_50,
    input  logic        KEY0,
    input  logic        en,
    input  logic        clr,
    output logic [3:0]  bcd_out,
    input  logic [0:6]  seg_in,
    output logic [0:6]  HEX0,
    output logic [0:6]  HEX1,
    output logic [0:6]  HEX2,
    output logic [0:6]  HEX3,
    output logic [1:0]  digit_sel,
    output logic [15:0] count,
    output logic        carry_out
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;

    // ------------------------------------------------------------------
    // Count tick divider
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_div;
    logic          tick;

    assign tick = en && (tick_div == TW'(TICK_DIV - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            tick_div <= '0;
        end else if (clr) begin
            tick_div <= '0;
        end else if (en) begin
            tick_div <= tick ? '0 : tick_div + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Decade chain: each stage is enabled by the previous stage's carry
    // ------------------------------------------------------------------
    logic [NDIG-1:0] dig_inc;
    logic [NDIG-1:0] dig_carry;

    assign dig_inc = {dig_carry[NDIG-2:0], tick};

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit_cell u_cell (
            .clk   (CLOCK_50),
            .rst_n (KEY0),
            .inc   (dig_inc[g]),
            .clr   (clr),
            .digit (count[4*g +: 4]),
            .carry (dig_carry[g])
        );
    end

    // The top stage's carry only exists during the wrapping tick; clr
    // suppresses both the wrap and the pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            carry_out <= 1'b0;
        end else begin
            carry_out <= dig_carry[NDIG-1] && !clr;
        end
    end

    // ------------------------------------------------------------------
    // Scan slot divider (free-running)
    // ------------------------------------------------------------------
    logic [SW-1:0] scan_div;
    logic          scan_tick;

    assign scan_tick = (scan_div == SW'(SCAN_DIV - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            scan_div <= '0;
        end else begin
            scan_div <= scan_tick ? '0 : scan_div + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    scan_state_t state, state_d;
    logic        drive_ld;
    logic        capture_ld;

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        drive_ld   = 1'b0;
        capture_ld = 1'b0;
        case (state)
            IDLE: begin
                if (scan_tick)
                    state_d = DRIVE;
            end
            DRIVE: begin
                drive_ld = 1'b1;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                capture_ld = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit drive / capture datapath
    // ------------------------------------------------------------------
    logic [0:6] hex_q [NDIG];
    logic       blank_d;
    logic       blank_q;

    // Blank decision is taken from the same count sample as bcd_out, so a
    // count change between DRIVE and CAPTURE cannot split the two.
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    assign blank_d = (digit_sel != 2'd0) && upper_digits_zero(count, digit_sel);
`else
    assign blank_d = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!KEY0) begin
            bcd_out   <= '0;
            digit_sel <= '0;
            blank_q   <= 1'b0;
            for (int unsigned k = 0; k < NDIG; k++)
                hex_q[k] <= SEG_BLANK;
        end else begin
            if (drive_ld) begin
                bcd_out <= bcd_digit(count, digit_sel);
                blank_q <= blank_d;
            end
            if (capture_ld) begin
                hex_q[digit_sel] <= blank_q ? SEG_BLANK : seg_in;
                digit_sel        <= digit_sel + 2'd1;
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];

endmodule

// File: doc/bcd_scan_ctrl.md
Name: bcd_scan_ctrl

Overview:
- Four-digit decade (BCD) counter with a display sequencer that time-shares one external combinational BCD-to-7-segment decoder across HEX0..HEX3.
- Per scan slot: presents one digit's BCD code to the shared decoder, captures the returned active-low segment pattern (index order 0:6 = a..g) into that digit's display register.
- Sits between board clock/keys and the existing single-digit decoder; top level wires bcd_out/seg_in to one decoder instance.

Parameters:
- TICK_DIV, 50000000, CLOCK_50 cycles per count tick (1 Hz at 50 MHz); must be >= 2.
- SCAN_DIV, 50000, CLOCK_50 cycles per scan slot; must be >= 3.

Ports:
- CLOCK_50  in  1  system clock; all logic rising-edge.
- KEY0  in  1  synchronous active-low reset.
- en  in  1  count enable; high lets count ticks advance the counter.
- clr  in  1  synchronous counter clear, active-high.
- bcd_out  out  4  BCD code driven to the shared decoder (registered).
- seg_in  in  7 [0:6]  decoder segment result for bcd_out.
- HEX0, HEX1, HEX2, HEX3  out  7 each [0:6]  held segment patterns, active-low; HEX0 = units.
- digit_sel  out  2  digit index currently being driven/captured.
- count  out  16  packed BCD value {d3,d2,d1,d0}.
- carry_out  out  1  one-cycle pulse on 9999->0000 wrap.

Behaviour:
- Reset (KEY0 low at clock edge): count = 0, both dividers = 0, state = IDLE, digit_sel = 0, bcd_out = 0, carry_out = 0, HEX0..3 = 7'b1111111 (blank). Reset dominates all inputs, in any state, including mid-scan.
- Tick divider: counts 0..TICK_DIV-1 while en = 1; holds while en = 0. tick = 1 for one cycle at terminal value, then divider returns to 0.
- Counter: on tick, d0 increments; digit 9 -> 0 with carry into the next digit. At 9999, tick -> 0000 and carry_out = 1 the following cycle for exactly one cycle.
- Non-BCD digit values are unreachable; no recovery logic required.
- clr = 1: count = 0 and tick divider = 0 at that edge. clr beats a coincident tick; no carry_out.
- Scan divider: free-running 0..SCAN_DIV-1, independent of en/clr; emits scan_tick at terminal value.
- FSM states: IDLE, DRIVE, CAPTURE.
  - IDLE -> DRIVE on scan_tick.
  - DRIVE: bcd_out <= digit[digit_sel], sampled from count at this edge. Unconditional -> CAPTURE.
  - CAPTURE: HEX[digit_sel] <= seg_in; digit_sel <= digit_sel + 1 (wraps 3 -> 0). Unconditional -> IDLE.
- Latency: HEX update is 2 cycles after scan_tick. A full refresh takes 4 scan slots.
- Count change between DRIVE and CAPTURE: the captured pattern still matches the latched bcd_out. The new value appears on the next visit to that digit.
- scan_tick while not in IDLE: cannot occur (SCAN_DIV >= 3). No queuing.
- HEX registers change only in CAPTURE and only for the selected digit.

Optional Feature:
- Macro BCD_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: in CAPTURE, digit k (k = 1..3) is written 7'b1111111 when digit k and all higher digits are 0 at the DRIVE sample. HEX0 is never blanked.
- Undefined: seg_in is always captured, so leading zeros are shown.

Decomposition:
- Shared package bcd_scan_pkg:
  - FSM state encoding (IDLE = 2'd0, DRIVE = 2'd1, CAPTURE = 2'd2).
  - SEG_BLANK = 7'b1111111.
  - BCD_MAX = 4'd9.
  - NDIG = 4.
- One natural sub-module, bcd_digit_cell: single decade stage with inputs inc and clr, outputs digit[3:0] and carry. Instantiate four times in a ripple-enable chain.

Test Plan (TICK_DIV = 4, SCAN_DIV = 3, testbench models the decoder combinationally from bcd_out):
- Reset, then KEY0 high with en = 0 for 40 cycles -> count = 0000, HEX0..3 = 7'b0000001 after 4 scan slots; digit_sel sequence 0,1,2,3,0.
- en = 1 for 40 cycles -> count = 0010, carry_out never asserted; HEX1 = 7'b1001111 and HEX0 = 7'b0000001 after the next refresh.
- Preload to 9998 by ticking, en = 1 -> 9999 then 0000; carry_out high exactly one cycle, one cycle after the wrap tick.
- Assert clr on the same cycle as tick with count = 0123 -> count = 0000, no increment, carry_out = 0.
- Pull KEY0 low during CAPTURE of digit 2 -> next cycle: state IDLE, digit_sel = 0, HEX2 = 7'b1111111, count = 0000.
- With BCD_SCAN_LEADING_ZERO_BLANK_EN and count = 0007 -> HEX3..1 = 7'b1111111, HEX0 = 7'b0001111. Without the macro -> HEX3..1 = 7'b0000001.
